// File: rtl/rca_pkg.sv
// Shared definitions for the wide add/subtract sequencer: slice width and FSM encoding.
package rca_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : rca_pkg

// File: rtl/fulladder_16bit.sv
// 16-bit ripple-carry adder: one full-adder cell per bit, carry rippling LSB to MSB.
module fulladder_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [16:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar g = 0; g < 16; g++) begin : g_cell
    assign o_sum[g]       = i_a[g] ^ i_b[g] ^ w_carry[g];
    assign w_carry[g + 1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_carry[16];

endmodule : fulladder_16bit

// File: rtl/rca_wide_add_seq.sv
// Multi-precision add/subtract sequencer: one shared 16-bit adder processes a
// WORDS*16-bit operand pair one slice per cycle, LSW first, with a registered
// inter-slice carry. Valid/ready handshakes on both the request and result side.
module rca_wide_add_seq
  import rca_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORDS*16-1:0]   in_a,
  input  logic [WORDS*16-1:0]   in_b,
  input  logic                  in_sub,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDS*16-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int W     = WORDS * WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [W-1:0]       r_op_a;
  logic [W-1:0]       r_op_b;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [WORD_W-1:0]  w_slice_a;
  logic [WORD_W-1:0]  w_slice_b;
  logic [WORD_W-1:0]  w_slice_sum;
  logic               w_slice_cout;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_last    = (r_idx == IDX_W'(WORDS - 1));
  assign w_slice_a = r_op_a[r_idx*WORD_W +: WORD_W];
  assign w_slice_b = r_op_b[r_idx*WORD_W +: WORD_W];

  fulladder_16bit u_fulladder_16bit (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: accept in IDLE, sweep slices in RUN, hold result in DONE.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then add one slice per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtract is A + ~B + 1, so the inversion and the +1 happen here once.
      r_op_a  <= in_a;
      r_op_b  <= in_sub ? ~in_b : in_b;
      r_carry <= in_sub ? 1'b1 : in_cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx*WORD_W +: WORD_W] <= w_slice_sum;
      r_carry <= w_slice_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_slice_cout;
        r_ovf  <= (r_op_a[W-1] == r_op_b[W-1]) && (w_slice_sum[WORD_W-1] != r_op_a[W-1]);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;

endmodule : rca_wide_add_seq

// File: tb/tb_rca_wide_add_seq.sv
// Directed bench for rca_wide_add_seq with WORDS=4 (64-bit operands).
module tb_rca_wide_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_sub;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  int tests = 0;
  int fails = 0;

  rca_wide_add_seq #(.WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for the result, check it, then drain it.
  // Called and returns one time unit after a rising edge.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic cin,
                       input logic [63:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int n;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after the accept edge; the latched op must not notice.
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_sub = ~sub; in_cin = ~cin;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'd4);
    check({tag, ".sum"}, out_sum, exp_sum);
    check({tag, ".cout"}, 64'(out_cout), 64'(exp_cout));
    check({tag, ".ovf"}, 64'(out_ovf), 64'(exp_ovf));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drain_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] held_sum;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.busy",      64'(busy),      64'd0);
    check("rst.sum",       out_sum,        64'd0);
    check("rst.cout",      64'(out_cout),  64'd0);
    check("rst.ovf",       64'(out_ovf),   64'd0);

    // 1..4: arithmetic corner cases
    do_op("t1.add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    do_op("t2.sub_borrow", 64'h0000_0000_0001_0000, 64'h1, 1'b1, 1'b0,
          64'h0000_0000_0000_FFFF, 1'b1, 1'b0);
    do_op("t3.add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_op("t3.sub_neg", 64'h0, 64'h1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    do_op("t4.add_cin", 64'h0, 64'h0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b0);
    do_op("t4.sub_cin_ign", 64'h5, 64'h5, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);

    // 5: backpressure with a competing request
    in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h1111_1111_1111_1111;
    in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 64'hDEAD_BEEF_DEAD_BEEF; in_b = 64'h0123_4567_89AB_CDEF; in_sub = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5.latency", 64'(n), 64'd4);
    held_sum = 64'h2345_6789_ABCD_F001;
    for (int i = 0; i < 5; i++) begin
      check("t5.hold_valid", 64'(out_valid), 64'd1);
      check("t5.hold_sum",   out_sum,        held_sum);
      check("t5.hold_cout",  64'(out_cout),  64'd0);
      check("t5.hold_ovf",   64'(out_ovf),   64'd0);
      check("t5.in_ready",   64'(in_ready),  64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("t5.idle_ready", 64'(in_ready),  64'd1);
    check("t5.idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("t5.no_accept",  64'(busy),      64'd0);

    // 6: reset during the 2nd RUN cycle, then a clean op
    in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h1; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6.valid", 64'(out_valid), 64'd0);
    check("t6.ready", 64'(in_ready),  64'd1);
    check("t6.busy",  64'(busy),      64'd0);
    do_op("t6.after_rst", 64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_rca_wide_add_seq
